aes_mask_arbiter: RTL and testbench

Sequencer and arbiter that shares one aes_mask engine between two requesters, e.g. an encipher core and a decipher core. It grants the engine round-robin and issues the init pulse only when the key owner changes or the key is invalidated. It then issues next, waits for the engine's ready, captures the 128-bit mask and returns it with a one-cycle done pulse. A watchdog aborts a hung engine.

---
 rtl/aes_mask_arbiter_if.sv | 46 ++++
 rtl/aes_mask_arbiter.sv | 164 ++++++++++++++++
 tb/tb_aes_mask_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/aes_mask_arbiter_if.sv
// Bundle of the two requester ports and the shared aes_mask engine port.
// slave  : the arbiter's view (takes requests, drives the engine).
// master : the environment's view (requesters plus engine model).
interface aes_mask_arbiter_if;
  // requester 0
  logic         req0;
  logic [127:0] key0;
  logic         keylen0;
  logic [127:0] block0;
  logic         rekey0;
  logic         done0;
  // requester 1
  logic         req1;
  logic [127:0] key1;
  logic         keylen1;
  logic [127:0] block1;
  logic         rekey1;
  logic         done1;
  // result returned to the granted requester
  logic [127:0] mask_out;
  logic         mask_err;
  // engine side
  logic         mask_init;
  logic         mask_next;
  logic [127:0] mask_key;
  logic         mask_keylen;
  logic [127:0] mask_block;
  logic         mask_ready;
  logic [127:0] mask_result;

  modport slave (
    input  req0, key0, keylen0, block0, rekey0,
    input  req1, key1, keylen1, block1, rekey1,
    input  mask_ready, mask_result,
    output done0, done1, mask_out, mask_err,
    output mask_init, mask_next, mask_key, mask_keylen, mask_block
  );

  modport master (
    output req0, key0, keylen0, block0, rekey0,
    output req1, key1, keylen1, block1, rekey1,
    output mask_ready, mask_result,
    input  done0, done1, mask_out, mask_err,
    input  mask_init, mask_next, mask_key, mask_keylen, mask_block
  );
endinterface

// File: rtl/aes_mask_arbiter.sv
// Round-robin sequencer sharing one aes_mask engine between two requesters.
// The engine key is only re-initialised when the key owner changes or the
// loaded key has been invalidated; a watchdog aborts a hung engine.
module aes_mask_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic               clk,
  input logic               reset,
  aes_mask_arbiter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT_START,
    S_INIT_SKIP,
    S_INIT_WAIT,
    S_NEXT_START,
    S_NEXT_SKIP,
    S_NEXT_WAIT,
    S_DONE
  } state_t;

  // Abort happens on the wait cycle in which the counter would reach TIMEOUT.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t       r_state, w_state_next;
  logic         r_grant, w_grant_next;
  logic         r_last_grant, w_last_grant_next;
  logic         r_key_valid, w_key_valid_next;
  logic         r_key_owner, w_key_owner_next;
  logic [15:0]  r_cnt, w_cnt_next;
  logic [127:0] r_mask_out, w_mask_out_next;
  logic         r_mask_err, w_mask_err_next;

  logic         w_pick;       // requester chosen in IDLE
  logic         w_rekey_cur;  // rekey aimed at the currently loaded owner
  logic         w_key_hit;    // loaded key belongs to w_pick and is still good

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_grant      <= 1'b0;
      r_last_grant <= 1'b1;
      r_key_valid  <= 1'b0;
      r_key_owner  <= 1'b0;
      r_cnt        <= '0;
      r_mask_out   <= '0;
      r_mask_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_grant_next;
      r_key_valid  <= w_key_valid_next;
      r_key_owner  <= w_key_owner_next;
      r_cnt        <= w_cnt_next;
      r_mask_out   <= w_mask_out_next;
      r_mask_err   <= w_mask_err_next;
    end
  end

  // Next-state logic: arbitration, sequencing, watchdog and key bookkeeping.
  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    w_key_valid_next  = r_key_valid;
    w_key_owner_next  = r_key_owner;
    w_cnt_next        = r_cnt;
    w_mask_out_next   = r_mask_out;
    w_mask_err_next   = r_mask_err;

    w_pick      = (bus.req0 && bus.req1) ? ~r_last_grant : bus.req1;
    w_rekey_cur = r_key_owner ? bus.rekey1 : bus.rekey0;
    w_key_hit   = r_key_valid && !w_rekey_cur && (r_key_owner == w_pick);

    case (r_state)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          w_grant_next      = w_pick;
          w_last_grant_next = w_pick;
          w_state_next      = w_key_hit ? S_NEXT_START : S_INIT_START;
        end
      end
      S_INIT_START: begin
        // Engine key is being replaced: the old one is gone either way.
        w_key_valid_next = 1'b0;
        w_state_next     = S_INIT_SKIP;
      end
      S_INIT_SKIP: begin
        w_cnt_next   = '0;
        w_state_next = S_INIT_WAIT;
      end
      S_INIT_WAIT: begin
        if (bus.mask_ready) begin
          w_key_valid_next = 1'b1;
          w_key_owner_next = r_grant;
          w_state_next     = S_NEXT_START;
        end else if (r_cnt == TMO_LAST) begin
          w_cnt_next       = r_cnt + 16'd1;
          w_mask_out_next  = '0;
          w_mask_err_next  = 1'b1;
          w_key_valid_next = 1'b0;
          w_state_next     = S_DONE;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_NEXT_START: begin
        w_state_next = S_NEXT_SKIP;
      end
      S_NEXT_SKIP: begin
        w_cnt_next   = '0;
        w_state_next = S_NEXT_WAIT;
      end
      S_NEXT_WAIT: begin
        if (bus.mask_ready) begin
          w_mask_out_next = bus.mask_result;
          w_mask_err_next = 1'b0;
          w_state_next    = S_DONE;
        end else if (r_cnt == TMO_LAST) begin
          w_cnt_next       = r_cnt + 16'd1;
          w_mask_out_next  = '0;
          w_mask_err_next  = 1'b1;
          w_key_valid_next = 1'b0;
          w_state_next     = S_DONE;
        end else begin
          w_cnt_next = r_cnt + 16'd1;
        end
      end
      S_DONE: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase

    // Rekey is checked against the owner as it will be after this cycle, so
    // a rekey coinciding with init completion for the same requester wins.
    if ((bus.rekey0 && !w_key_owner_next) || (bus.rekey1 && w_key_owner_next)) begin
      w_key_valid_next = 1'b0;
    end
  end

  // Engine strobes, grant muxes and done pulses decoded from the state.
  always_comb begin
    bus.mask_init   = (r_state == S_INIT_START);
    bus.mask_next   = (r_state == S_NEXT_START);
    bus.done0       = (r_state == S_DONE) && !r_grant;
    bus.done1       = (r_state == S_DONE) &&  r_grant;
    bus.mask_key    = '0;
    bus.mask_keylen = 1'b0;
    bus.mask_block  = '0;
    if (r_state != S_IDLE) begin
      bus.mask_key    = r_grant ? bus.key1    : bus.key0;
      bus.mask_keylen = r_grant ? bus.keylen1 : bus.keylen0;
      bus.mask_block  = r_grant ? bus.block1  : bus.block0;
    end
    bus.mask_out = r_mask_out;
    bus.mask_err = r_mask_err;
  end

endmodule

// File: tb/tb_aes_mask_arbiter.sv
// Directed bench for aes_mask_arbiter: cycle-accurate latency, key reuse,
// arbitration, rekey, watchdog and mid-operation reset.
module tb_aes_mask_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_mask_arbiter_if bus ();

  aes_mask_arbiter #(.TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  localparam logic [127:0] KEY0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] KEY1 = 128'h101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] BLK0 = 128'hb0b0b0b0_00000000_11111111_22222222;
  localparam logic [127:0] BLK1 = 128'hb1b1b1b1_33333333_44444444_55555555;
  localparam logic [127:0] RES_A = 128'hdeadbeef_01234567_89abcdef_cafef00d;
  localparam logic [127:0] RES_B = 128'h0badf00d_76543210_fedcba98_12345678;

  int n_vec = 0;
  int n_err = 0;

  // per-operation observations
  int           c_init_cnt;
  int           c_first_init;
  int           c_first_next;
  int           c_done0_cyc;
  int           c_done1_cyc;
  int           c_done0_cnt;
  int           c_done1_cnt;
  logic [127:0] c_init_key [2];
  logic         c_init_keylen [2];
  logic [127:0] c_out0, c_out1;
  logic         c_err0, c_err1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_rekey(input bit which);
    @(negedge clk);
    if (which) bus.rekey1 = 1'b1; else bus.rekey0 = 1'b1;
    @(negedge clk);
    bus.rekey0 = 1'b0;
    bus.rekey1 = 1'b0;
  endtask

  // Raise the requested reqs in an IDLE cycle (cycle 0) and watch until every
  // raised requester has seen done; each req drops right after its done.
  task automatic run_op(input bit r0, input bit r1, input int budget);
    int cyc;
    int dones;
    int want;
    want = int'(r0) + int'(r1);
    cyc = 0;
    dones = 0;
    c_init_cnt = 0; c_first_init = -1; c_first_next = -1;
    c_done0_cyc = -1; c_done1_cyc = -1; c_done0_cnt = 0; c_done1_cnt = 0;
    @(negedge clk);
    bus.req0 = r0;
    bus.req1 = r1;
    while (dones < want && cyc < budget) begin
      @(negedge clk);
      cyc++;
      n_vec++;
      assert (!(bus.mask_init && bus.mask_next)) else begin
        n_err++;
        $error("FAIL init_next_exclusive observed=1 expected=0 cycle=%0d", cyc);
      end
      if (bus.mask_init) begin
        if (c_init_cnt < 2) begin
          c_init_key[c_init_cnt]    = bus.mask_key;
          c_init_keylen[c_init_cnt] = bus.mask_keylen;
        end
        if (c_first_init < 0) c_first_init = cyc;
        c_init_cnt++;
      end
      if (bus.mask_next && c_first_next < 0) c_first_next = cyc;
      if (bus.done0) begin
        c_done0_cyc = cyc; c_done0_cnt++; c_out0 = bus.mask_out; c_err0 = bus.mask_err;
        bus.req0 = 1'b0; dones++;
      end
      if (bus.done1) begin
        c_done1_cyc = cyc; c_done1_cnt++; c_out1 = bus.mask_out; c_err1 = bus.mask_err;
        bus.req1 = 1'b0; dones++;
      end
    end
    chk("op_completed_in_budget", 128'(dones), 128'(want));
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
  endtask

  initial begin
    bus.req0 = 1'b0; bus.key0 = KEY0; bus.keylen0 = 1'b0; bus.block0 = BLK0; bus.rekey0 = 1'b0;
    bus.req1 = 1'b0; bus.key1 = KEY1; bus.keylen1 = 1'b1; bus.block1 = BLK1; bus.rekey1 = 1'b0;
    bus.mask_ready = 1'b1;
    bus.mask_result = RES_A;

    // Reset state
    do_reset();
    chk("rst_done0", 128'(bus.done0), 128'd0);
    chk("rst_done1", 128'(bus.done1), 128'd0);
    chk("rst_mask_out", bus.mask_out, 128'd0);
    chk("rst_mask_err", 128'(bus.mask_err), 128'd0);
    chk("rst_init_next", 128'({bus.mask_init, bus.mask_next}), 128'd0);
    chk("rst_mask_key", bus.mask_key, 128'd0);

    // Cold key for requester 0
    run_op(1'b1, 1'b0, 40);
    chk("cold_init_cycle", 128'(c_first_init), 128'd1);
    chk("cold_init_count", 128'(c_init_cnt), 128'd1);
    chk("cold_init_key", c_init_key[0], KEY0);
    chk("cold_next_cycle", 128'(c_first_next), 128'd4);
    chk("cold_done0_cycle", 128'(c_done0_cyc), 128'd7);
    chk("cold_mask_out", c_out0, RES_A);
    chk("cold_mask_err", 128'(c_err0), 128'd0);
    chk("cold_no_done1", 128'(c_done1_cnt), 128'd0);

    // Warm key, same requester
    bus.mask_result = RES_B;
    run_op(1'b1, 1'b0, 40);
    chk("warm_init_count", 128'(c_init_cnt), 128'd0);
    chk("warm_next_cycle", 128'(c_first_next), 128'd1);
    chk("warm_done0_cycle", 128'(c_done0_cyc), 128'd4);
    chk("warm_mask_out", c_out0, RES_B);

    // Simultaneous requests after reset: 0 first, then 1 with a fresh init
    do_reset();
    bus.mask_result = RES_A;
    run_op(1'b1, 1'b1, 60);
    chk("tie_done0_cycle", 128'(c_done0_cyc), 128'd7);
    chk("tie_done1_cycle", 128'(c_done1_cyc), 128'd15);
    chk("tie_done0_count", 128'(c_done0_cnt), 128'd1);
    chk("tie_done1_count", 128'(c_done1_cnt), 128'd1);
    chk("tie_init_count", 128'(c_init_cnt), 128'd2);
    chk("tie_init_key0", c_init_key[0], KEY0);
    chk("tie_init_key1", c_init_key[1], KEY1);
    chk("tie_init_keylen1", 128'(c_init_keylen[1]), 128'd1);
    chk("tie_mask_out1", c_out1, RES_A);

    // Rekey: owner moves back to 0, rekey1 harmless, rekey0 forces init
    run_op(1'b1, 1'b0, 40);
    chk("owner_change_init", 128'(c_init_cnt), 128'd1);
    pulse_rekey(1'b1);
    run_op(1'b1, 1'b0, 40);
    chk("rekey1_no_init", 128'(c_init_cnt), 128'd0);
    pulse_rekey(1'b0);
    run_op(1'b1, 1'b0, 40);
    chk("rekey0_init", 128'(c_init_cnt), 128'd1);
    chk("rekey0_done0_cycle", 128'(c_done0_cyc), 128'd7);

    // Watchdog: engine never ready in NEXT_WAIT
    bus.mask_ready = 1'b0;
    bus.mask_result = RES_B;
    run_op(1'b1, 1'b0, 60);
    chk("tmo_done0_count", 128'(c_done0_cnt), 128'd1);
    chk("tmo_mask_err", 128'(c_err0), 128'd1);
    chk("tmo_mask_out", c_out0, 128'd0);
    @(negedge clk);
    @(negedge clk);
    chk("tmo_err_held", 128'(bus.mask_err), 128'd1);
    bus.mask_ready = 1'b1;
    run_op(1'b1, 1'b0, 40);
    chk("tmo_reinit", 128'(c_init_cnt), 128'd1);
    chk("tmo_recover_err", 128'(c_err0), 128'd0);
    chk("tmo_recover_out", c_out0, RES_B);

    // Reset while in NEXT_WAIT (warm key: NEXT_WAIT from cycle 3)
    bus.mask_ready = 1'b0;
    @(negedge clk);
    bus.req0 = 1'b1;
    c_done0_cnt = 0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (bus.done0) c_done0_cnt++;
    end
    reset = 1'b1;
    bus.req0 = 1'b0;
    @(negedge clk);
    if (bus.done0) c_done0_cnt++;
    chk("midrst_no_done", 128'(c_done0_cnt), 128'd0);
    chk("midrst_mask_out", bus.mask_out, 128'd0);
    chk("midrst_mask_err", 128'(bus.mask_err), 128'd0);
    chk("midrst_mask_key", bus.mask_key, 128'd0);
    chk("midrst_init_next", 128'({bus.mask_init, bus.mask_next}), 128'd0);
    reset = 1'b0;
    bus.mask_ready = 1'b1;
    bus.mask_result = RES_A;
    run_op(1'b1, 1'b0, 40);
    chk("midrst_reinit", 128'(c_init_cnt), 128'd1);
    chk("midrst_done0_cycle", 128'(c_done0_cyc), 128'd7);
    chk("midrst_mask_out_after", c_out0, RES_A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
